// File: rtl/sobel3x3_accel_if.sv
// SRAM Bank 0 read port: req/gnt request phase plus rvalid data return.
// The accelerator drives the master modport; the SRAM side uses the slave modport.
interface sobel3x3_accel_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) ();
  logic              sram_req;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_gnt;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_rvalid;

  modport master (
    output sram_req, sram_addr,
    input  sram_gnt, sram_rdata, sram_rvalid
  );

  modport slave (
    input  sram_req, sram_addr,
    output sram_gnt, sram_rdata, sram_rvalid
  );
endinterface

// File: rtl/sobel3x3_accel.sv
// 3x3 Sobel window engine: fetches nine pixels around a centre address, convolves with Gx/Gy
// and compares to a threshold. Define SOBEL3X3_ABS_EN to compare the saturated |acc| instead.
module sobel3x3_accel #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned ROW_STRIDE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   center_addr,
  input  logic                mode,
  input  logic [ACC_W-1:0]    threshold,
  sobel3x3_accel_if.master    sram,
  output logic                busy,
  output logic                done,
  output logic                match,
  output logic [ACC_W-1:0]    result
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CMP, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [3:0]          k_q, k_d;
  logic                req_q, req_d;
  logic                out_q, out_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ADDR_W-1:0]   center_q, center_d;
  logic                mode_q, mode_d;
  logic [ACC_W-1:0]    thr_q, thr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                match_q, match_d;
  logic [ACC_W-1:0]    result_q, result_d;

  logic                rv_hit;
  logic                last_k;
  logic                req_now;
  logic [3:0]          req_k;
  logic [PIX_W-1:0]    pix;
  logic                cmp_match;
  logic                unused_rdata_hi;

  // Tap address k=3r+c relative to the centre, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] c, input logic [3:0] k);
    logic [ADDR_W-1:0] a;
    a = c;
    if (k < 4'd3)       a = a - ADDR_W'(ROW_STRIDE);
    else if (k >= 4'd6) a = a + ADDR_W'(ROW_STRIDE);
    if (k == 4'd0 || k == 4'd3 || k == 4'd6)      a = a - ADDR_W'(1);
    else if (k == 4'd2 || k == 4'd5 || k == 4'd8) a = a + ADDR_W'(1);
    return a;
  endfunction

  // Weighted tap in two's complement; weights are 0, +-1 or +-2.
  function automatic logic [ACC_W-1:0] tap_term(input logic m, input logic [3:0] k,
                                                  input logic [PIX_W-1:0] p);
    logic [ACC_W-1:0] p1;
    logic [ACC_W-1:0] p2;
    logic [ACC_W-1:0] t;
    p1 = ACC_W'(p);
    p2 = p1 << 1;
    t  = '0;
    if (!m) begin
      case (k)
        4'd0, 4'd6: t = -p1;
        4'd2, 4'd8: t = p1;
        4'd3:       t = -p2;
        4'd5:       t = p2;
        default:    t = '0;
      endcase
    end else begin
      case (k)
        4'd0, 4'd2: t = -p1;
        4'd1:       t = -p2;
        4'd6, 4'd8: t = p1;
        4'd7:       t = p2;
        default:    t = '0;
      endcase
    end
    return t;
  endfunction

  assign pix             = sram.sram_rdata[PIX_W-1:0];
  assign unused_rdata_hi = ^sram.sram_rdata[DATA_W-1:PIX_W];
  assign rv_hit          = (state_q == S_FETCH) && out_q && sram.sram_rvalid;
  assign last_k          = (k_q == 4'd8);

  // Next request may be issued in the same cycle the previous pixel returns.
  assign req_now         = (state_q == S_FETCH) && (req_q || (rv_hit && !last_k));
  assign req_k           = req_q ? k_q : 4'(k_q + 4'd1);
  assign sram.sram_req   = req_now;
  assign sram.sram_addr  = req_now ? tap_addr(center_q, req_k) : '0;

  always_comb begin
`ifdef SOBEL3X3_ABS_EN
    logic [ACC_W-1:0] mag;
    mag = acc_q;
    if (acc_q[ACC_W-1]) begin
      mag = (acc_q == {1'b1, {(ACC_W-1){1'b0}}}) ? {1'b0, {(ACC_W-1){1'b1}}} : -acc_q;
    end
    cmp_match = $signed(mag) > $signed(thr_q);
`else
    cmp_match = $signed(acc_q) > $signed(thr_q);
`endif
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    req_d    = req_q;
    out_d    = out_q;
    acc_d    = acc_q;
    center_d = center_q;
    mode_d   = mode_q;
    thr_d    = thr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    match_d  = match_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_FETCH;
          center_d = center_addr;
          mode_d   = mode;
          thr_d    = threshold;
          acc_d    = '0;
          k_d      = 4'd0;
          req_d    = 1'b1;
          out_d    = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          match_d  = 1'b0;
        end
      end
      S_FETCH: begin
        if (rv_hit) begin
          acc_d = acc_q + tap_term(mode_q, k_q, pix);
          if (last_k) begin
            state_d = S_CMP;
            req_d   = 1'b0;
            out_d   = 1'b0;
          end else begin
            k_d   = 4'(k_q + 4'd1);
            req_d = !sram.sram_gnt;
            out_d = sram.sram_gnt;
          end
        end else if (req_q && sram.sram_gnt) begin
          req_d = 1'b0;
          out_d = 1'b1;
        end
      end
      S_CMP: begin
        result_d = acc_q;
        match_d  = cmp_match;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      req_q    <= 1'b0;
      out_q    <= 1'b0;
      acc_q    <= '0;
      center_q <= '0;
      mode_q   <= 1'b0;
      thr_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      req_q    <= req_d;
      out_q    <= out_d;
      acc_q    <= acc_d;
      center_q <= center_d;
      mode_q   <= mode_d;
      thr_q    <= thr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      match_q  <= match_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign match  = match_q;
  assign result = result_q;

endmodule

// File: doc/sobel3x3_accel.md
# sobel3x3_accel

Parametrised 3x3 Sobel window engine for the user domain, sitting between the MMIO control registers and SRAM Bank 0. It gathers a 3x3 pixel neighbourhood around a programmable centre address using a req/gnt/rvalid handshake. It convolves the neighbourhood with a runtime-selectable horizontal or vertical Sobel kernel, then compares the result against a runtime threshold. It exposes the signed result, a match flag and busy/done status.

## Interface
- `ADDR_W`, 10: SRAM word-address width.
- `DATA_W`, 32: SRAM read-data width.
- `PIX_W`, 8: pixel width, taken from `sram_rdata[PIX_W-1:0]` as an unsigned value.
- `ACC_W`, 16: signed accumulator, threshold and result width. Must satisfy `ACC_W >= PIX_W+4`.
- `ROW_STRIDE`, 16: image row pitch in SRAM words.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: level; sampled only in IDLE or DONE.
- `center_addr`  in  ADDR_W: window centre word address, latched when `start` is accepted.
- `mode`  in  1: kernel select, latched at start. 0 = Gx, 1 = Gy.
- `threshold`  in  ACC_W: signed threshold, latched at start.
- `sram_req`  out  1: read request.
- `sram_addr`  out  ADDR_W: read address, valid while `sram_req` is high.
- `sram_gnt`  in  1: request accepted this cycle.
- `sram_rdata`  in  DATA_W: read data.
- `sram_rvalid`  in  1: read data valid, one per granted request.
- `busy`  out  1: high in FETCH and CMP.
- `done`  out  1: result valid; sticky until the next accepted start.
- `match`  out  1: threshold result.
- `result`  out  ACC_W: signed convolution sum.

## Operation
- State IDLE: `start` -> FETCH. On entry to FETCH: latch inputs, clear accumulator, set k=0.
- State FETCH: read pixel k=0..8 in row-major order (k=3r+c).
  - Address = `center_addr + (r-1)*ROW_STRIDE + (c-1)`, computed modulo 2^ADDR_W (wrap-around, no clipping).
  - At most one outstanding request.
  - `sram_req` stays high with a stable address until `sram_gnt`, then drops until `sram_rvalid`.
  - The next request may assert in the same cycle as the previous `sram_rvalid`.
- Accumulate on each `sram_rvalid`: `acc += K[k] * zero_ext(pixel)`, signed ACC_W.
  - Gx = {-1,0,1,-2,0,2,-1,0,1}.
  - Gy = {-1,-2,-1,0,0,0,1,2,1}.
  - Zero-weight taps are still fetched.
- After the 9th `rvalid` -> CMP.
- State CMP (1 cycle): register `result`=acc and `match` (see Configuration), then -> DONE.
- State DONE: `done`=1 and outputs hold. `start` -> FETCH, clearing `done`/`match` on that edge. Otherwise stay in DONE.
- `start` while busy is ignored. `sram_rvalid` outside FETCH is ignored.
- Reset values, asynchronous: state IDLE, `sram_req`=0, `sram_addr`=0, `busy`=0, `done`=0, `match`=0, `result`=0. Reset mid-FETCH abandons the operation; a late `rvalid` after reset is ignored.

## Timing
- `start` is sampled at edge E0. First `sram_req` is high in the cycle after E0.
- With zero-wait SRAM (gnt in the request cycle, rvalid one cycle later):
  - pixel k is requested in cycle k+1 and accumulated at edge E(k+2);
  - CMP occupies the cycle after E10;
  - `done`, `match` and `result` are valid from E11, i.e. 11 cycles after start.
- Each gnt wait cycle or rvalid wait cycle adds one cycle of latency.
- `busy` rises at E0 and falls at E11, the same edge on which `done` rises.

## Configuration
- `SOBEL3X3_ABS_EN` defined: `match = (|acc| > threshold)`. The absolute value saturates at 2^(ACC_W-1)-1. `result` still holds the signed acc.
- Not defined: `match = ($signed(acc) > $signed(threshold))`. Negative edges never match unless the threshold is negative.

## Test plan
- Gx, flat window (all pixels 10), threshold 100, centre 128 -> addresses 111,112,113,127,128,129,143,144,145; result 0, match 0, done at E11.
- Gx, left column 0, middle column 50, right column 200, threshold 100 -> result 800, match 1.
- Gy, top row 200, other rows 0, threshold 100 -> result -800. Match 0 without `SOBEL3X3_ABS_EN`, 1 with it.
- Random gnt delays of 0-3 cycles and rvalid delays of 1-3 cycles, Gx vertical-edge image -> result identical to zero-wait; never more than one outstanding request; address stable while req is high and gnt is low.
- Centre 0 -> first address 1023-16=1007 (wrap). `start` pulsed mid-FETCH -> ignored. Back-to-back start from DONE -> `done` drops at the accept edge, new result at E11.
- `rst_n` low during pixel 4 -> all outputs return to reset values immediately. A stale `rvalid` after reset is ignored. The next run produces the correct result.
